fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the decode-stage controller and feeds its `instr` input.
- Owns the PC register and the instruction-memory request/ready handshake.
- Owns the IF/ID pipeline register, including stall, flush and redirect handling.
- Redirect sources are a taken branch resolved in M and a jump resolved in D.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on bubble or flush.

Ports:
- clka  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- stallD  in  1  hazard unit: hold IF/ID contents.
- flushD  in  1  hazard unit: load a bubble into IF/ID.
- pcsrcM  in  1  branch taken, resolved in M.
- pc_branchM  in  32  branch target.
- jumpD  in  1  jump in decode (controller `jump`).
- jump_addrD  in  32  jump target.
- inst_req  out  1  memory request valid.
- inst_addr  out  32  request address; held stable while inst_req=1 and inst_ready=0.
- inst_rdata  in  32  instruction returned by memory.
- inst_ready  in  1  memory data valid; completes the request this cycle.
- instrD  out  32  IF/ID instruction; goes to the controller and the datapath.
- pcD  out  32  IF/ID PC.
- pcplus4D  out  32  IF/ID PC+4.
- validD  out  1  instrD is a real instruction (not a bubble).
- fetch_busy  out  1  request outstanding and not yet ready.

Behaviour:

Reset (rst=0 at a clock edge):
- pcF=RESET_PC; addr_q=0; kill=0; state=IDLE.
- instrD=NOP_INSTR, pcD=0, pcplus4D=0, validD=0.
- inst_req=0, hold buffer=0.
- Reset taken mid-request: the in-flight response is ignored, with no kill bookkeeping.

FSM states: IDLE, REQ, HOLD.
- **IDLE:** inst_req=0. Next cycle goes to REQ with addr_q=pcF.
- **REQ:** inst_req=1, inst_addr=addr_q.
- **HOLD:** inst_req=0. Fetched word sits in the hold buffer.

Redirect:
- redirect = pcsrcM | jumpD.
- target = pcsrcM ? pc_branchM : jump_addrD. Branch has priority over jump because it is the older instruction.

REQ, inst_ready=1:
- **Discard case** (kill=1 or redirect=1): word is discarded. pcF=addr_q=(redirect ? target : pcF); kill=0; stay in REQ.
- **Stall case** (stallD=1): word goes to the hold buffer; state goes to HOLD.
- **Normal case:** IF/ID takes {rdata, addr_q, addr_q+4, valid=1}; pcF=addr_q=addr_q+4; stay in REQ.

REQ, inst_ready=0:
- If redirect: pcF=target and kill=1. addr_q is unchanged (the handshake must stay stable).
- When ready later arrives, the discard case applies and the request is reissued at pcF.

HOLD:
- If redirect: buffer is dropped; pcF=addr_q=target; go to REQ.
- Else if !stallD: IF/ID takes the buffer; pcF=addr_q=addr_q+4; go to REQ.
- Else: remain in HOLD.

IF/ID register priority (highest first):
1. rst.
2. flushD, or any redirect with stallD=0: load a bubble (NOP_INSTR, validD=0).
3. stallD: hold.
4. Valid fetch: load the fetched word.
5. Otherwise: load a bubble.

Other rules:
- All PC arithmetic is modulo 2^32; PC 32'hFFFF_FFFC wraps to 0.
- Minimum latency with zero-wait memory (ready in the same cycle as req): 1 cycle from request to instrD, with 1 instruction per cycle sustained.
- fetch_busy = (state==REQ) & ~inst_ready.

Optional Feature:
- Macro FETCH_PERF_EN.
- **When defined:** adds outputs perf_fetch_cnt[31:0] and perf_kill_cnt[31:0].
  - perf_fetch_cnt increments on every valid IF/ID load.
  - perf_kill_cnt increments on every discarded response or dropped hold buffer.
  - Both counters clear on reset and saturate at 32'hFFFF_FFFF.
- **When undefined:** neither the ports nor the logic exist; behaviour is otherwise identical.

Decomposition:
- Shared pipeline package holds: FSM state encoding (IDLE=2'd0, REQ=2'd1, HOLD=2'd2), NOP_INSTR, RESET_PC.
- One sub-module: the IF/ID register (ifid_reg). Parametrised width, with en (=~stallD) and clr (flush/bubble) inputs, reusing the codebase's floprc style but with active-low synchronous reset.

Test Plan:
1. Reset, then zero-wait memory returning addr-derived words → instrD sequence 0x0,0x4,0x8 appear on consecutive cycles with validD=1; first valid instrD appears 2 cycles after rst deasserts.
2. Memory with 3-cycle latency → inst_addr stable for 3 cycles, fetch_busy=1 for 2 of them, bubble (validD=0) in between.
3. stallD=1 for 4 cycles while a word returns → state HOLD, inst_req=0, instrD unchanged; word appears the cycle after stallD drops, with no PC skip.
4. jumpD=1 with jump_addrD=0x100 while a request is pending → response discarded, next inst_addr=0x100, IF/ID bubble inserted.
5. pcsrcM=1 (pc_branchM=0x40) and jumpD=1 (0x80) in the same cycle → next fetch address is 0x40.
6. flushD and stallD both asserted → IF/ID cleared to NOP_INSTR with validD=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// +----------------------------------------------------------------------+
// | fetch_stage_pkg : shared fetch-stage encodings and reset constants    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    // IF/ID payload: {valid, pc+4, pc, instr}
    localparam int IFID_W = 97;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_ifid_reg.sv
// +----------------------------------------------------------------------+
// | ifid_reg : enable/clear pipeline register, active-low sync reset     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int                 WIDTH   = IFID_W,
    parameter logic [WIDTH-1:0]   CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear outranks enable so a flush wins over a stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= CLR_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +----------------------------------------------------------------------+
// | fetch_stage : PC, imem req/ready handshake and IF/ID register         |
// | Optional macro FETCH_PERF_EN adds fetch/kill counters. Revision 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        pcsrcM,
    input  logic [31:0] pc_branchM,
    input  logic        jumpD,
    input  logic [31:0] jump_addrD,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        inst_ready,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic        fetch_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_kill_cnt
`endif
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc_f, pc_f_nx;
    logic [31:0]  addr_q, addr_q_nx;
    logic [31:0]  hold_buf, hold_buf_nx;
    logic         kill, kill_nx;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  addr_plus4;
    logic         fetch_valid;
    logic [31:0]  fetch_word;
    logic         ifid_clr;
    logic [IFID_W-1:0] ifid_d, ifid_q;

    assign redirect   = pcsrcM | jumpD;
    // Branch in M is older than the jump in D, so it wins.
    assign target     = pcsrcM ? pc_branchM : jump_addrD;
    assign addr_plus4 = addr_q + 32'd4;

    always_ff @(posedge clka) begin
        if (!rst) begin
            state    <= IDLE;
            pc_f     <= RESET_PC;
            addr_q   <= '0;
            kill     <= 1'b0;
            hold_buf <= '0;
        end else begin
            state    <= state_nx;
            pc_f     <= pc_f_nx;
            addr_q   <= addr_q_nx;
            kill     <= kill_nx;
            hold_buf <= hold_buf_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pc_f_nx     = pc_f;
        addr_q_nx   = addr_q;
        kill_nx     = kill;
        hold_buf_nx = hold_buf;
        fetch_valid = 1'b0;
        fetch_word  = inst_rdata;
        case (state)
            IDLE: begin
                state_nx  = REQ;
                addr_q_nx = pc_f;
            end
            REQ: begin
                if (inst_ready) begin
                    if (kill || redirect) begin
                        pc_f_nx   = redirect ? target : pc_f;
                        addr_q_nx = redirect ? target : pc_f;
                        kill_nx   = 1'b0;
                    end else if (stallD) begin
                        hold_buf_nx = inst_rdata;
                        state_nx    = HOLD;
                    end else begin
                        fetch_valid = 1'b1;
                        pc_f_nx     = addr_plus4;
                        addr_q_nx   = addr_plus4;
                    end
                end else if (redirect) begin
                    // addr_q must stay put until the outstanding request completes.
                    pc_f_nx = target;
                    kill_nx = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_f_nx   = target;
                    addr_q_nx = target;
                    state_nx  = REQ;
                end else if (!stallD) begin
                    fetch_valid = 1'b1;
                    fetch_word  = hold_buf;
                    pc_f_nx     = addr_plus4;
                    addr_q_nx   = addr_plus4;
                    state_nx    = REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign inst_req   = (state == REQ);
    assign inst_addr  = addr_q;
    assign fetch_busy = (state == REQ) & ~inst_ready;

    // A redirect never yields fetch_valid, so it bubbles through the second term.
    assign ifid_clr = flushD | (~stallD & ~fetch_valid);
    assign ifid_d   = {1'b1, addr_plus4, addr_q, fetch_word};

    ifid_reg #(
        .WIDTH   (IFID_W),
        .CLR_VAL ({1'b0, 32'h0, 32'h0, NOP_INSTR})
    ) u_ifid (
        .clk (clka),
        .rst (rst),
        .en  (~stallD),
        .clr (ifid_clr),
        .d   (ifid_d),
        .q   (ifid_q)
    );

    assign validD   = ifid_q[96];
    assign pcplus4D = ifid_q[95:64];
    assign pcD      = ifid_q[63:32];
    assign instrD   = ifid_q[31:0];

`ifdef FETCH_PERF_EN
    logic discard;
    logic valid_load;

    assign discard    = ((state == REQ) & inst_ready & (kill | redirect)) |
                        ((state == HOLD) & redirect);
    assign valid_load = fetch_valid & ~flushD;

    always_ff @(posedge clka) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_kill_cnt  <= '0;
        end else begin
            if (valid_load && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (discard && (perf_kill_cnt != 32'hFFFF_FFFF)) begin
                perf_kill_cnt <= perf_kill_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
